active_prefix_builder: RTL

ACTIVE_PREFIX_BUILDER -- requirements
Module: active_prefix_builder

---
 rtl/active_prefix_builder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/active_prefix_builder.sv
// -----------------------------------------------------------------------------
// active_prefix_builder
//
// Purpose:
//   Builds a growing prefix of 4-bit low-entropy symbols. Each prefix is offered
//   to an external combinational codebook. When the codebook reports a match, the
//   codeword is handed to a downstream bit packer. If the prefix reaches 16
//   nibbles with no match, a sticky overflow flag is raised. In that case the
//   prefix is discarded.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   sym_valid_i/sym_i     incoming symbol ('hF is the terminal symbol)
//   sym_ready_o           high while the builder can take a symbol
//   ap_cnt_o/ap_data_o    registered active prefix (newest nibble at LSB)
//   encode_match_i,
//   encode_length_i,
//   encode_data_i         combinational codebook answer for the current prefix
//   cw_valid_o/cw_ready_i codeword handshake toward the bit packer
//   cw_length_o/cw_data_o codeword held stable while cw_valid_o is high
//   overflow_o            sticky: prefix hit 16 nibbles without a match
//   cw_count_o            (AP_STATS_EN only) saturating codeword handshake count
//
// Configuration macro: AP_STATS_EN adds cw_count_o and its counter.
// -----------------------------------------------------------------------------
module active_prefix_builder #(
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  input  logic [3:0]                     sym_i,
  output logic                           sym_ready_o,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  input  logic                           encode_match_i,
  input  logic [5:0]                     encode_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   encode_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           overflow_o
`ifdef AP_STATS_EN
  ,
  output logic [15:0]                    cw_count_o
`endif
);

  typedef enum logic [1:0] {
    ACCEPT,
    LOOKUP,
    EMIT
  } state_e;

  localparam logic [5:0] PrefixMax = 6'd16;

  state_e                         state_q, state_d;
  logic [5:0]                     apCnt_q, apCnt_d;
  logic [CODEBOOK_LENGTH_MAX-1:0] apData_q, apData_d;
  logic [5:0]                     cwLength_q, cwLength_d;
  logic [ENCODE_DATALENGTH-1:0]   cwData_q, cwData_d;
  logic                           overflow_q, overflow_d;

  // All state registers. The asynchronous reset drops every pending prefix or
  // codeword at once. Because the FSM decodes cw_valid_o directly, it falls in
  // the same instant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ACCEPT;
      apCnt_q    <= '0;
      apData_q   <= '0;
      cwLength_q <= '0;
      cwData_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      apCnt_q    <= apCnt_d;
      apData_q   <= apData_d;
      cwLength_q <= cwLength_d;
      cwData_q   <= cwData_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic. The codebook is consulted only in LOOKUP, against the
  // registered prefix. This limits throughput to one symbol every two cycles.
  // It also keeps the codebook's combinational path off the symbol input.
  always_comb begin
    state_d    = state_q;
    apCnt_d    = apCnt_q;
    apData_d   = apData_q;
    cwLength_d = cwLength_q;
    cwData_d   = cwData_q;
    overflow_d = overflow_q;
    case (state_q)
      ACCEPT: begin
        if (sym_valid_i) begin
          apData_d = {apData_q[CODEBOOK_LENGTH_MAX-5:0], sym_i};
          apCnt_d  = apCnt_q + 6'd1;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (encode_match_i) begin
          cwLength_d = encode_length_i;
          cwData_d   = encode_data_i;
          apCnt_d    = '0;
          apData_d   = '0;
          state_d    = EMIT;
        end else if (apCnt_q >= PrefixMax) begin
          // A full prefix with no match can never match. Drop it and flag it.
          overflow_d = 1'b1;
          apCnt_d    = '0;
          apData_d   = '0;
          state_d    = ACCEPT;
        end else begin
          state_d = ACCEPT;
        end
      end
      EMIT: begin
        if (cw_ready_i) begin
          state_d = ACCEPT;
        end
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

`ifdef AP_STATS_EN
  logic [15:0] cwCount_q;

  // Counts accepted codewords. The count saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cwCount_q <= '0;
    end else if ((state_q == EMIT) && cw_ready_i && (cwCount_q != 16'hFFFF)) begin
      cwCount_q <= cwCount_q + 16'd1;
    end
  end

  assign cw_count_o = cwCount_q;
`endif

  // sym_ready_o is gated by rst_n_i. During reset the state already reads
  // ACCEPT, but the builder must not advertise readiness.
  assign sym_ready_o = (state_q == ACCEPT) && rst_n_i;
  assign cw_valid_o  = (state_q == EMIT);
  assign ap_cnt_o    = apCnt_q;
  assign ap_data_o   = apData_q;
  assign cw_length_o = cwLength_q;
  assign cw_data_o   = cwData_q;
  assign overflow_o  = overflow_q;

endmodule
